// File: rtl/fread_ram_loader.sv
// Boot-time loader: fetches DEPTH_BYTES of a file over the fread request/response
// interface in CHUNK_BYTES requests into on-chip RAM, then serves word-wide reads.
module fread_ram_loader #(
    parameter int unsigned DEPTH_BYTES = 12288,
    parameter int unsigned CHUNK_BYTES = 2048,
    parameter int unsigned OUT_WIDTH   = 16,
    parameter logic [31:0] BASE_OFFSET = 32'h0,
    parameter bit          AUTO_START  = 1'b1,
    parameter int unsigned RD_AW       = 13
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 req_valid,
    input  logic                 req_ready,
    output logic [31:0]          req_offset,
    input  logic [7:0]           resp_data,
    input  logic                 resp_valid,
    output logic                 busy,
    output logic                 loaded,
    input  logic                 rd_en,
    input  logic [RD_AW-1:0]     rd_addr,
    output logic [OUT_WIDTH-1:0] rd_data
);
    localparam int unsigned NB    = OUT_WIDTH / 8;
    localparam int unsigned WORDS = DEPTH_BYTES / NB;
    localparam int unsigned MAW   = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned BCW   = $clog2(DEPTH_BYTES + 1);
    localparam int unsigned CCW   = $clog2(CHUNK_BYTES + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RECV = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]           state_r;
    logic [1:0]           next_state_s;
    logic [BCW-1:0]       byte_cnt_r;
    logic [BCW-1:0]       byte_nxt_s;
    logic [CCW-1:0]       chunk_cnt_r;
    logic [CCW-1:0]       chunk_nxt_s;
    logic                 last_byte_s;
    logic                 take_byte_s;
    logic                 enter_load_s;
    logic                 chunk_wrap_s;
    logic                 req_valid_r;
    logic [31:0]          req_offset_r;
    logic                 busy_r;
    logic                 loaded_r;
    logic [OUT_WIDTH-1:0] rd_data_r;
    int unsigned          bc_s;
    int unsigned          wr_lane_s;
    logic [MAW-1:0]       wr_word_s;
    logic [MAW-1:0]       rd_idx_s;
    logic [OUT_WIDTH-1:0] mem_r [WORDS];

    // Counter increments and byte-to-word/lane mapping of the write pointer.
    always_comb begin
        byte_nxt_s  = byte_cnt_r + BCW'(1);
        chunk_nxt_s = chunk_cnt_r + CCW'(1);
        last_byte_s = (byte_nxt_s == BCW'(DEPTH_BYTES));
        bc_s        = 32'(byte_cnt_r);
        wr_word_s   = MAW'(bc_s / NB);
        wr_lane_s   = bc_s % NB;
        rd_idx_s    = MAW'(rd_addr);
    end

    // Load sequencer next-state logic.
    always_comb begin
        next_state_s = state_r;
        take_byte_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start || AUTO_START) begin
                    next_state_s = ST_REQ;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (req_ready) begin
                    next_state_s = ST_RECV;
                end else begin
                    next_state_s = ST_REQ;
                end
            end
            ST_RECV: begin
                take_byte_s = resp_valid;
                if (resp_valid && last_byte_s) begin
                    next_state_s = ST_DONE;
                end else if (resp_valid && (chunk_nxt_s == CCW'(CHUNK_BYTES))) begin
                    next_state_s = ST_REQ;
                end else begin
                    next_state_s = ST_RECV;
                end
            end
            ST_DONE: begin
                if (start) begin
                    next_state_s = ST_REQ;
                end else begin
                    next_state_s = ST_DONE;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
        enter_load_s = ((state_r == ST_IDLE) || (state_r == ST_DONE)) && (next_state_s == ST_REQ);
        chunk_wrap_s = take_byte_s && !last_byte_s && (chunk_nxt_s == CCW'(CHUNK_BYTES));
    end

    // State, counters and registered status outputs; loaded lags DONE entry by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            req_valid_r  <= 1'b0;
            req_offset_r <= BASE_OFFSET;
            busy_r       <= 1'b0;
            loaded_r     <= 1'b0;
            byte_cnt_r   <= BCW'(0);
            chunk_cnt_r  <= CCW'(0);
        end else begin
            state_r     <= next_state_s;
            req_valid_r <= (next_state_s == ST_REQ);
            busy_r      <= (next_state_s == ST_REQ) || (next_state_s == ST_RECV);
            loaded_r    <= (state_r == ST_DONE) && (next_state_s == ST_DONE);
            if (enter_load_s) begin
                req_offset_r <= BASE_OFFSET;
                byte_cnt_r   <= BCW'(0);
                chunk_cnt_r  <= CCW'(0);
            end else if (take_byte_s) begin
                byte_cnt_r <= byte_nxt_s;
                if (chunk_wrap_s) begin
                    chunk_cnt_r  <= CCW'(0);
                    req_offset_r <= req_offset_r + 32'(CHUNK_BYTES);
                end else begin
                    chunk_cnt_r  <= chunk_nxt_s;
                end
            end
        end
    end

    // Byte-lane write into the word-wide RAM; contents survive reset.
    always_ff @(posedge clk) begin
        if (take_byte_s) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_lane_s == 32'(i)) begin
                    mem_r[wr_word_s][8*i +: 8] <= resp_data;
                end
            end
        end
    end

    // Synchronous read port, only live once the image is complete.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_r <= {OUT_WIDTH{1'b0}};
        end else if (rd_en && loaded_r) begin
            rd_data_r <= mem_r[rd_idx_s];
        end else begin
            rd_data_r <= rd_data_r;
        end
    end

    assign req_valid  = req_valid_r;
    assign req_offset = req_offset_r;
    assign busy       = busy_r;
    assign loaded     = loaded_r;
    assign rd_data    = rd_data_r;
endmodule

// File: tb/tb_fread_ram_loader.sv
// Randomized bench for fread_ram_loader: two configurations driven by a byte
// responder, checked against a file-offset model of the expected RAM image.
module tb_fread_ram_loader;
    localparam int          DEP_A  = 12288;
    localparam int          CHK_A  = 2048;
    localparam int          NB_A   = 2;
    localparam logic [31:0] BASE_A = 32'h0;
    localparam int          DEP_B  = 100;
    localparam int          CHK_B  = 32;
    localparam int          NB_B   = 4;
    localparam logic [31:0] BASE_B = 32'h1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n_a, start_a, req_valid_a, req_ready_a, resp_valid_a, busy_a, loaded_a, rd_en_a;
    logic [31:0] req_offset_a;
    logic [7:0]  resp_data_a;
    logic [12:0] rd_addr_a;
    logic [15:0] rd_data_a;
    logic        rst_n_b, start_b, req_valid_b, req_ready_b, resp_valid_b, busy_b, loaded_b, rd_en_b;
    logic [31:0] req_offset_b;
    logic [7:0]  resp_data_b;
    logic [4:0]  rd_addr_b;
    logic [31:0] rd_data_b;

    fread_ram_loader #(.DEPTH_BYTES(DEP_A), .CHUNK_BYTES(CHK_A), .OUT_WIDTH(16),
                       .BASE_OFFSET(BASE_A), .AUTO_START(1'b1), .RD_AW(13)) u_dut_a (
        .clk(clk), .rst_n(rst_n_a), .start(start_a), .req_valid(req_valid_a),
        .req_ready(req_ready_a), .req_offset(req_offset_a), .resp_data(resp_data_a),
        .resp_valid(resp_valid_a), .busy(busy_a), .loaded(loaded_a), .rd_en(rd_en_a),
        .rd_addr(rd_addr_a), .rd_data(rd_data_a));

    fread_ram_loader #(.DEPTH_BYTES(DEP_B), .CHUNK_BYTES(CHK_B), .OUT_WIDTH(32),
                       .BASE_OFFSET(BASE_B), .AUTO_START(1'b0), .RD_AW(5)) u_dut_b (
        .clk(clk), .rst_n(rst_n_b), .start(start_b), .req_valid(req_valid_b),
        .req_ready(req_ready_b), .req_offset(req_offset_b), .resp_data(resp_data_b),
        .resp_valid(resp_valid_b), .busy(busy_b), .loaded(loaded_b), .rd_en(rd_en_b),
        .rd_addr(rd_addr_b), .rd_data(rd_data_b));

    int          n_tests = 0;
    int          n_fail  = 0;
    int          rem [2];
    int          lat [2];
    int          sent [2];
    int          in_chunk [2];
    int          req_idx [2];
    int          done_cd [2];
    int          hold [2];
    bit          reqv_exp [2];
    bit          stray [2];
    logic [31:0] nxt_off [2];
    logic [7:0]  key [2];
    logic [31:0] last_rd [2];

    function automatic int depth_of(input int d);
        return (d == 0) ? DEP_A : DEP_B;
    endfunction
    function automatic int chunk_of(input int d);
        return (d == 0) ? CHK_A : CHK_B;
    endfunction
    function automatic int nb_of(input int d);
        return (d == 0) ? NB_A : NB_B;
    endfunction
    function automatic logic [31:0] base_of(input int d);
        return (d == 0) ? BASE_A : BASE_B;
    endfunction

    // Expected word: file byte at offset o is o[7:0]^key, packed little-endian.
    function automatic logic [31:0] exp_word(input int d, input int w);
        logic [31:0] v;
        logic [31:0] off;
        v = 32'h0;
        for (int i = 0; i < nb_of(d); i++) begin
            off = base_of(d) + 32'(w * nb_of(d) + i);
            v[8*i +: 8] = off[7:0] ^ key[d];
        end
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic model_reset(input int d);
        rem[d] = 0; lat[d] = 0; sent[d] = 0; in_chunk[d] = 0;
        req_idx[d] = 0; done_cd[d] = 0; reqv_exp[d] = 1'b0;
    endtask

    // One clock of the responder: observe at negedge, then drive for the next posedge.
    task automatic step(input int d);
        logic        rv, bz, ld, rdy, v;
        logic [31:0] ro;
        logic [7:0]  dat;
        @(negedge clk);
        if (d == 0) begin
            rv = req_valid_a; ro = req_offset_a; bz = busy_a; ld = loaded_a;
        end else begin
            rv = req_valid_b; ro = req_offset_b; bz = busy_b; ld = loaded_b;
        end
        if (done_cd[d] == 2) begin
            check("busy_after_last", 32'(bz), 32'h0);
            check("loaded_after_last", 32'(ld), 32'h0);
            done_cd[d] = 1;
        end else if (done_cd[d] == 1) begin
            check("loaded_rise", 32'(ld), 32'h1);
            done_cd[d] = 0;
        end
        if (reqv_exp[d]) begin
            check("req_after_chunk", 32'(rv), 32'h1);
            reqv_exp[d] = 1'b0;
        end
        if (rv) check("busy_in_req", 32'(bz), 32'h1);
        if (hold[d] > 0) begin
            rdy = 1'b0;
            hold[d]--;
        end else begin
            rdy = ($urandom_range(0, 3) != 0);
        end
        if (rv && rdy) begin
            check("req_offset", ro, base_of(d) + 32'(chunk_of(d) * req_idx[d]));
            req_idx[d]++;
            rem[d] = chunk_of(d);
            nxt_off[d] = ro;
            lat[d] = int'($urandom_range(1, 3));
        end
        v = 1'b0;
        dat = 8'($urandom);
        if (rem[d] > 0) begin
            if (lat[d] > 0) begin
                lat[d]--;
            end else if ($urandom_range(0, 7) != 0) begin
                v = 1'b1;
                dat = nxt_off[d][7:0] ^ key[d];
                nxt_off[d] = nxt_off[d] + 32'h1;
                rem[d]--;
                if (sent[d] < depth_of(d)) begin
                    sent[d]++;
                    in_chunk[d]++;
                    if (sent[d] == depth_of(d)) begin
                        done_cd[d] = 2;
                    end else if (in_chunk[d] == chunk_of(d)) begin
                        reqv_exp[d] = 1'b1;
                        in_chunk[d] = 0;
                    end
                end
            end
        end else if (rv && !rdy && stray[d] && ($urandom_range(0, 1) == 1)) begin
            v = 1'b1;
        end
        if (d == 0) begin
            req_ready_a = rdy; resp_valid_a = v; resp_data_a = dat;
        end else begin
            req_ready_b = rdy; resp_valid_b = v; resp_data_b = dat;
        end
    endtask

    task automatic run_until_loaded(input int d);
        int n;
        bit ok;
        n = 0;
        ok = 1'b0;
        while (!ok && n < 40000) begin
            step(d);
            n++;
            ok = ((d == 0) ? loaded_a : loaded_b) && (done_cd[d] == 0) && (rem[d] == 0);
        end
        check("load_finished", 32'(ok), 32'h1);
    endtask

    task automatic run_until_sent(input int d, input int target);
        int n;
        n = 0;
        while (sent[d] < target && n < 20000) begin
            step(d);
            n++;
        end
        check("bytes_progress", 32'(sent[d] >= target), 32'h1);
    endtask

    task automatic read_chk(input int d, input int w);
        if (d == 0) begin
            rd_en_a = 1'b1; rd_addr_a = 13'(w);
        end else begin
            rd_en_b = 1'b1; rd_addr_b = 5'(w);
        end
        step(d);
        rd_en_a = 1'b0;
        rd_en_b = 1'b0;
        check("rd_data", (d == 0) ? 32'(rd_data_a) : rd_data_b, exp_word(d, w));
        last_rd[d] = exp_word(d, w);
    endtask

    task automatic hold_chk(input int d, input bit en);
        if (d == 0) begin
            rd_en_a = en; rd_addr_a = 13'($urandom_range(0, DEP_A / NB_A - 1));
        end else begin
            rd_en_b = en; rd_addr_b = 5'($urandom_range(0, DEP_B / NB_B - 1));
        end
        step(d);
        rd_en_a = 1'b0;
        rd_en_b = 1'b0;
        check("rd_hold", (d == 0) ? 32'(rd_data_a) : rd_data_b, last_rd[d]);
    endtask

    task automatic reset_chk(input int d);
        if (d == 0) begin
            check("rst_req_valid", 32'(req_valid_a), 32'h0);
            check("rst_req_offset", req_offset_a, BASE_A);
            check("rst_busy", 32'(busy_a), 32'h0);
            check("rst_loaded", 32'(loaded_a), 32'h0);
            check("rst_rd_data", 32'(rd_data_a), 32'h0);
        end else begin
            check("rst_req_valid", 32'(req_valid_b), 32'h0);
            check("rst_req_offset", req_offset_b, BASE_B);
            check("rst_busy", 32'(busy_b), 32'h0);
            check("rst_loaded", 32'(loaded_b), 32'h0);
            check("rst_rd_data", rd_data_b, 32'h0);
        end
    endtask

    initial begin
        rst_n_a = 1'b0; start_a = 1'b0; req_ready_a = 1'b0; resp_valid_a = 1'b0;
        resp_data_a = 8'h0; rd_en_a = 1'b0; rd_addr_a = 13'h0;
        rst_n_b = 1'b0; start_b = 1'b0; req_ready_b = 1'b0; resp_valid_b = 1'b0;
        resp_data_b = 8'h0; rd_en_b = 1'b0; rd_addr_b = 5'h0;
        for (int d = 0; d < 2; d++) begin
            model_reset(d);
            hold[d] = 0; stray[d] = 1'b0; key[d] = 8'h5A; last_rd[d] = 32'h0; nxt_off[d] = 32'h0;
        end
        @(negedge clk);
        reset_chk(0);
        reset_chk(1);
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;

        // B: no auto start; stays idle until start, then a stalled first request.
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("idle_req_valid", 32'(req_valid_b), 32'h0);
            check("idle_busy", 32'(busy_b), 32'h0);
        end
        hold_chk(1, 1'b1);
        hold[1] = 12;
        stray[1] = 1'b1;
        start_b = 1'b1;
        step(1);
        start_b = 1'b0;
        check("start_req_valid", 32'(req_valid_b), 32'h1);
        check("start_loaded", 32'(loaded_b), 32'h0);
        for (int i = 0; i < 10; i++) begin
            step(1);
            check("stall_req_valid", 32'(req_valid_b), 32'h1);
            check("stall_req_offset", req_offset_b, BASE_B);
        end
        run_until_loaded(1);
        check("b_request_count", 32'(req_idx[1]), 32'd4);
        read_chk(1, 3);
        for (int w = 0; w < DEP_B / NB_B; w++) read_chk(1, w);
        hold_chk(1, 1'b0);
        check("a_waiting_valid", 32'(req_valid_a), 32'h1);
        check("a_waiting_offset", req_offset_a, BASE_A);

        // A: full default load, then reads.
        run_until_loaded(0);
        check("a_request_count", 32'(req_idx[0]), 32'd6);
        read_chk(0, 0);
        for (int i = 0; i < 12; i++) read_chk(0, int'($urandom_range(0, DEP_A / NB_A - 1)));
        read_chk(0, 0);
        hold_chk(0, 1'b0);

        // A: reload with new contents, ignored start while busy, reset mid-load.
        key[0] = 8'hC3;
        model_reset(0);
        start_a = 1'b1;
        step(0);
        start_a = 1'b0;
        check("reload_loaded", 32'(loaded_a), 32'h0);
        check("reload_req_valid", 32'(req_valid_a), 32'h1);
        run_until_sent(0, 500);
        start_a = 1'b1;
        step(0);
        start_a = 1'b0;
        check("start_while_busy", 32'(busy_a), 32'h1);
        hold_chk(0, 1'b1);
        run_until_sent(0, 3000);
        rst_n_a = 1'b0;
        #1;
        reset_chk(0);
        model_reset(0);
        req_ready_a = 1'b0;
        resp_valid_a = 1'b0;
        @(negedge clk);
        rst_n_a = 1'b1;
        run_until_loaded(0);
        check("restart_request_count", 32'(req_idx[0]), 32'd6);
        read_chk(0, 0);
        for (int i = 0; i < 12; i++) read_chk(0, int'($urandom_range(0, DEP_A / NB_A - 1)));
        read_chk(0, DEP_A / NB_A - 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
